// File: rtl/systolic_tile_if.sv
// Handshake and data bundle for systolic_tile: weight-row load channel,
// activation stream, deskewed result stream and busy status.
interface systolic_tile_if #(
  parameter int unsigned ROWS       = 4,
  parameter int unsigned COLS       = 4,
  parameter int unsigned A_BITWIDTH = 8,
  parameter int unsigned P_BITWIDTH = 32
);
  logic                         w_valid;
  logic                         w_ready;
  logic [COLS*A_BITWIDTH-1:0]   w_data;
  logic [COLS*P_BITWIDTH-1:0]   bias;
  logic                         a_valid;
  logic                         a_ready;
  logic [ROWS*A_BITWIDTH-1:0]   a_data;
  logic                         a_last;
  logic                         o_valid;
  logic [COLS*P_BITWIDTH-1:0]   o_data;
  logic                         busy;

  modport master (
    output w_valid, w_data, bias, a_valid, a_data, a_last,
    input  w_ready, a_ready, o_valid, o_data, busy
  );

  modport slave (
    input  w_valid, w_data, bias, a_valid, a_data, a_last,
    output w_ready, a_ready, o_valid, o_data, busy
  );
endinterface

// File: rtl/systolic_tile.sv
// Weight-stationary ROWS x COLS systolic MAC tile: input skew, PE array with
// bias injection at row 0, output deskew, and an IDLE/LOAD/COMPUTE/DRAIN FSM.
module systolic_tile #(
  parameter int unsigned ROWS       = 4,
  parameter int unsigned COLS       = 4,
  parameter int unsigned A_BITWIDTH = 8,
  parameter int unsigned P_BITWIDTH = 32
) (
  input  logic           clk,
  input  logic           rst,
  systolic_tile_if.slave bus
);
  localparam int unsigned LAT   = ROWS + COLS - 1;
  localparam int unsigned ROW_W = (ROWS > 1) ? $clog2(ROWS) : 1;
  localparam int unsigned DRN_W = $clog2(LAT + 1);
  localparam int unsigned M_W   = 2 * A_BITWIDTH;

  typedef enum logic [1:0] {S_IDLE, S_LOAD, S_COMPUTE, S_DRAIN} state_t;

  state_t             r_state;
  state_t             w_state_nxt;
  logic [ROW_W-1:0]   r_row_cnt;
  logic [ROW_W-1:0]   w_row_nxt;
  logic [DRN_W-1:0]   r_drn_cnt;
  logic [DRN_W-1:0]   w_drn_nxt;
  logic               r_wts_valid;
  logic               r_w_ready;
  logic               r_a_ready;
  logic               r_busy;
  logic               w_w_ready_nxt;
  logic               w_a_ready_nxt;
  logic               w_busy_nxt;
  logic               w_w_acc;
  logic               w_a_acc;
  logic               w_load_done;

  logic [A_BITWIDTH-1:0] r_w    [ROWS][COLS];
  logic [P_BITWIDTH-1:0] r_bias [COLS];

  // PE-to-PE links: activation/tag entering PE(i,j), and PE(i,j) psum/tag out.
  logic [A_BITWIDTH-1:0] w_a_in [ROWS][COLS];
  logic                  w_v_in [ROWS][COLS];
  logic [P_BITWIDTH-1:0] w_p    [ROWS][COLS];
  logic                  w_pv   [ROWS][COLS];

  logic [P_BITWIDTH-1:0] w_col_p [COLS];
  logic [COLS-1:0]       w_col_v;

  logic                  r_o_valid;
  logic [COLS*P_BITWIDTH-1:0] r_o_data;

  assign w_w_acc = bus.w_valid & r_w_ready;
  assign w_a_acc = bus.a_valid & r_a_ready;

  // Next state, counters and the next value of the registered status outputs.
  always_comb begin
    w_state_nxt   = r_state;
    w_row_nxt     = r_row_cnt;
    w_drn_nxt     = r_drn_cnt;
    w_load_done   = 1'b0;
    w_w_ready_nxt = 1'b0;
    w_a_ready_nxt = 1'b0;
    w_busy_nxt    = 1'b0;
    case (r_state)
      S_IDLE, S_LOAD: begin
        if (w_w_acc) begin
          if (r_row_cnt == ROW_W'(ROWS - 1)) begin
            w_row_nxt   = '0;
            w_load_done = 1'b1;
            w_state_nxt = S_COMPUTE;
          end else begin
            w_row_nxt   = r_row_cnt + ROW_W'(1);
            w_state_nxt = S_LOAD;
          end
        end else if ((r_state == S_IDLE) && r_wts_valid && bus.a_valid) begin
          w_state_nxt = S_COMPUTE;
        end
      end
      S_COMPUTE: begin
        if (w_a_acc && bus.a_last) begin
          w_state_nxt = S_DRAIN;
          w_drn_nxt   = '0;
        end
      end
      S_DRAIN: begin
        if (r_drn_cnt == DRN_W'(LAT - 1)) begin
          w_state_nxt = S_IDLE;
          w_drn_nxt   = '0;
        end else begin
          w_drn_nxt   = r_drn_cnt + DRN_W'(1);
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
    w_w_ready_nxt = (w_state_nxt == S_IDLE) || (w_state_nxt == S_LOAD);
    w_a_ready_nxt = (w_state_nxt == S_COMPUTE);
    w_busy_nxt    = (w_state_nxt != S_IDLE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state   <= S_IDLE;
      r_row_cnt <= '0;
      r_drn_cnt <= '0;
      r_w_ready <= 1'b1;
      r_a_ready <= 1'b0;
      r_busy    <= 1'b0;
    end else begin
      r_state   <= w_state_nxt;
      r_row_cnt <= w_row_nxt;
      r_drn_cnt <= w_drn_nxt;
      r_w_ready <= w_w_ready_nxt;
      r_a_ready <= w_a_ready_nxt;
      r_busy    <= w_busy_nxt;
    end
  end

  // Stationary weights are overwritten row by row; bias is taken with the last row.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_wts_valid <= 1'b0;
      for (int i = 0; i < ROWS; i++) begin
        for (int j = 0; j < COLS; j++) begin
          r_w[i][j] <= '0;
        end
      end
      for (int j = 0; j < COLS; j++) begin
        r_bias[j] <= '0;
      end
    end else if (w_w_acc) begin
      for (int j = 0; j < COLS; j++) begin
        r_w[r_row_cnt][j] <= bus.w_data[j*A_BITWIDTH +: A_BITWIDTH];
      end
      if (w_load_done) begin
        r_wts_valid <= 1'b1;
        for (int j = 0; j < COLS; j++) begin
          r_bias[j] <= bus.bias[j*P_BITWIDTH +: P_BITWIDTH];
        end
      end
    end
  end

  // Input skew: lane i is delayed i cycles; idle cycles inject zero with tag 0.
  for (genvar gi = 0; gi < ROWS; gi++) begin : g_skew
    logic [A_BITWIDTH-1:0] w_lane;
    assign w_lane = w_a_acc ? bus.a_data[gi*A_BITWIDTH +: A_BITWIDTH] : '0;
    if (gi == 0) begin : g_direct
      assign w_a_in[gi][0] = w_lane;
      assign w_v_in[gi][0] = w_a_acc;
    end else begin : g_delay
      logic [A_BITWIDTH-1:0] r_sk_a [gi];
      logic                  r_sk_v [gi];
      always_ff @(posedge clk) begin
        if (rst) begin
          for (int k = 0; k < gi; k++) begin
            r_sk_a[k] <= '0;
            r_sk_v[k] <= 1'b0;
          end
        end else begin
          r_sk_a[0] <= w_lane;
          r_sk_v[0] <= w_a_acc;
          for (int k = 1; k < gi; k++) begin
            r_sk_a[k] <= r_sk_a[k-1];
            r_sk_v[k] <= r_sk_v[k-1];
          end
        end
      end
      assign w_a_in[gi][0] = r_sk_a[gi-1];
      assign w_v_in[gi][0] = r_sk_v[gi-1];
    end
  end

  // PE array: psum flows down, activation and tag flow right.
  for (genvar gi = 0; gi < ROWS; gi++) begin : g_row
    for (genvar gj = 0; gj < COLS; gj++) begin : g_col
      logic signed [M_W-1:0]  w_prod;
      logic [P_BITWIDTH-1:0]  w_p_top;
      logic                   w_v_top;
      logic [P_BITWIDTH-1:0]  r_p;
      logic                   r_pv;

      assign w_prod = M_W'($signed(w_a_in[gi][gj])) * M_W'($signed(r_w[gi][gj]));

      if (gi == 0) begin : g_top
        assign w_p_top = r_bias[gj];
        assign w_v_top = 1'b1;
      end else begin : g_mid
        assign w_p_top = w_p[gi-1][gj];
        assign w_v_top = w_pv[gi-1][gj];
      end

      always_ff @(posedge clk) begin
        if (rst) begin
          r_p  <= '0;
          r_pv <= 1'b0;
        end else begin
          r_p  <= w_p_top + P_BITWIDTH'(w_prod);
          r_pv <= w_v_top & w_v_in[gi][gj];
        end
      end
      assign w_p[gi][gj]  = r_p;
      assign w_pv[gi][gj] = r_pv;

      if (gj < COLS - 1) begin : g_fwd
        logic [A_BITWIDTH-1:0] r_a;
        logic                  r_v;
        always_ff @(posedge clk) begin
          if (rst) begin
            r_a <= '0;
            r_v <= 1'b0;
          end else begin
            r_a <= w_a_in[gi][gj];
            r_v <= w_v_in[gi][gj];
          end
        end
        assign w_a_in[gi][gj+1] = r_a;
        assign w_v_in[gi][gj+1] = r_v;
      end
    end
  end

  // Output deskew: column j is delayed COLS-1-j cycles so all lanes align.
  for (genvar gj = 0; gj < COLS; gj++) begin : g_deskew
    localparam int unsigned D = COLS - 1 - gj;
    if (D == 0) begin : g_direct
      assign w_col_p[gj] = w_p[ROWS-1][gj];
      assign w_col_v[gj] = w_pv[ROWS-1][gj];
    end else begin : g_delay
      logic [P_BITWIDTH-1:0] r_ds_p [D];
      logic                  r_ds_v [D];
      always_ff @(posedge clk) begin
        if (rst) begin
          for (int k = 0; k < D; k++) begin
            r_ds_p[k] <= '0;
            r_ds_v[k] <= 1'b0;
          end
        end else begin
          r_ds_p[0] <= w_p[ROWS-1][gj];
          r_ds_v[0] <= w_pv[ROWS-1][gj];
          for (int k = 1; k < D; k++) begin
            r_ds_p[k] <= r_ds_p[k-1];
            r_ds_v[k] <= r_ds_v[k-1];
          end
        end
      end
      assign w_col_p[gj] = r_ds_p[D-1];
      assign w_col_v[gj] = r_ds_v[D-1];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_o_valid <= 1'b0;
      r_o_data  <= '0;
    end else begin
      r_o_valid <= &w_col_v;
      for (int j = 0; j < COLS; j++) begin
        r_o_data[j*P_BITWIDTH +: P_BITWIDTH] <= w_col_p[j];
      end
    end
  end

  assign bus.w_ready = r_w_ready;
  assign bus.a_ready = r_a_ready;
  assign bus.busy    = r_busy;
  assign bus.o_valid = r_o_valid;
  assign bus.o_data  = r_o_data;
endmodule
